// File: rtl/adder_pkg.sv
// Shared types and constants for the 2-bit adder and its downstream sum accumulator.
package adder_pkg;

  localparam int unsigned ADDER_OP_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Width of an unsigned sum of two operands of the given widths.
  function automatic int unsigned sum_width(input int unsigned a_w, input int unsigned b_w);
    return ((a_w > b_w) ? a_w : b_w) + 1;
  endfunction

  localparam int unsigned IN_W_DEFAULT = sum_width(ADDER_OP_W, ADDER_OP_W);

endpackage

// File: rtl/acc_datapath.sv
// Accumulator register with sticky overflow and result holding register.
// Define ACC_SAT_EN to saturate at 2^ACC_W-1 instead of wrapping.
module acc_datapath #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             add_en,
  input  logic             load_out,
  input  logic [IN_W-1:0]  in_sum,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int unsigned SUM_W = ACC_W + 1;

  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [SUM_W-1:0] sum_c;
  logic [ACC_W-1:0] acc_nxt_c;
  logic             ovf_nxt_c;

  // Next accumulator value; the extra sum bit is the carry out of the accumulator.
  always_comb begin
    sum_c     = {1'b0, acc} + SUM_W'(in_sum);
    acc_nxt_c = acc;
    ovf_nxt_c = ovf;
    if (add_en) begin
`ifdef ACC_SAT_EN
      if (sum_c[ACC_W]) begin
        acc_nxt_c = '1;
        ovf_nxt_c = 1'b1;
      end else begin
        acc_nxt_c = sum_c[ACC_W-1:0];
      end
`else
      acc_nxt_c = sum_c[ACC_W-1:0];
      ovf_nxt_c = ovf | sum_c[ACC_W];
`endif
    end
  end

  // The result registers capture the value including the final sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      ovf     <= 1'b0;
      out_acc <= '0;
      out_ovf <= 1'b0;
    end else begin
      if (clear) begin
        acc <= '0;
        ovf <= 1'b0;
      end else begin
        acc <= acc_nxt_c;
        ovf <= ovf_nxt_c;
      end
      if (load_out) begin
        out_acc <= acc_nxt_c;
        out_ovf <= ovf_nxt_c;
      end
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// Frame accumulator behind the 2-bit adder: sums N_SAMPLES handshaked inputs and holds the total.
// Build option ACC_SAT_EN selects saturating instead of wrapping accumulation.
module sum_accumulator
  import adder_pkg::*;
#(
  parameter int unsigned IN_W      = IN_W_DEFAULT,
  parameter int unsigned ACC_W     = 8,
  parameter int unsigned N_SAMPLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned CNT_W = 8;

  state_t           state;
  state_t           state_nxt_c;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt_c;
  logic             xfer_c;
  logic             last_c;
  logic             clear_c;

  assign xfer_c = in_valid && in_ready;
  assign last_c = xfer_c && (count == CNT_W'(N_SAMPLES - 1));

  // Next state, sample counter and accumulator clear.
  always_comb begin
    state_nxt_c = state;
    count_nxt_c = count;
    clear_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt_c = ST_ACCUM;
          count_nxt_c = '0;
          clear_c     = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (last_c) begin
          state_nxt_c = ST_HOLD;
          count_nxt_c = '0;
        end else if (xfer_c) begin
          count_nxt_c = count + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (start) begin
            state_nxt_c = ST_ACCUM;
            count_nxt_c = '0;
            clear_c     = 1'b1;
          end else begin
            state_nxt_c = ST_IDLE;
          end
        end
      end
      default: state_nxt_c = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they decode only flop outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt_c;
      count     <= count_nxt_c;
      in_ready  <= (state_nxt_c == ST_ACCUM);
      out_valid <= (state_nxt_c == ST_HOLD);
      busy      <= (state_nxt_c != ST_IDLE);
    end
  end

  acc_datapath #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_c),
    .add_en   (xfer_c),
    .load_out (last_c),
    .in_sum   (in_sum),
    .out_acc  (out_acc),
    .out_ovf  (out_ovf)
  );

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: two accumulators (ACC_W=8 and ACC_W=5) share one stimulus stream
// and are compared every cycle against a transaction-level model.
module tb_sum_accumulator;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, out_ready;
  logic [2:0] in_sum;

  logic       in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [7:0] out_acc_a;
  logic       in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [4:0] out_acc_b;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  sum_accumulator #(.IN_W(3), .ACC_W(8), .N_SAMPLES(N)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_sum(in_sum), .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
    .out_ovf(out_ovf_a), .busy(busy_a)
  );

  sum_accumulator #(.IN_W(3), .ACC_W(5), .N_SAMPLES(N)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_sum(in_sum), .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
    .out_ovf(out_ovf_b), .busy(busy_b)
  );

  // mode: 0 idle, 1 accumulating, 2 holding a result; total is the exact integer sum
  typedef struct {
    int mode;
    int cnt;
    int total;
    int exp_acc;
    int exp_ovf;
  } model_t;

  model_t ma, mb;

  function automatic int reduce(input int total, input int w);
    int mx;
    mx = (1 << w) - 1;
`ifdef ACC_SAT_EN
    return (total > mx) ? mx : total;
`else
    return total % (1 << w);
`endif
  endfunction

  function automatic model_t step(input model_t m, input int w, input bit r, input bit s,
                                  input bit iv, input bit ordy, input int x);
    model_t n;
    n = m;
    if (r) begin
      n = '{0, 0, 0, 0, 0};
    end else if (m.mode == 0) begin
      if (s) begin
        n.mode = 1; n.cnt = 0; n.total = 0;
      end
    end else if (m.mode == 1) begin
      if (iv) begin
        n.total = m.total + x;
        n.cnt   = m.cnt + 1;
        if (n.cnt == N) begin
          n.mode    = 2;
          n.exp_acc = reduce(n.total, w);
          n.exp_ovf = (n.total > (1 << w) - 1) ? 1 : 0;
        end
      end
    end else if (ordy) begin
      n.mode = s ? 1 : 0;
      if (s) begin
        n.cnt = 0; n.total = 0;
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    ma = step(ma, 8, rst, start, in_valid, out_ready, int'(in_sum));
    mb = step(mb, 5, rst, start, in_valid, out_ready, int'(in_sum));
  end

  // Cycle-by-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_in_ready",  32'(in_ready_a),  32'(ma.mode == 1));
      check("a_out_valid", 32'(out_valid_a), 32'(ma.mode == 2));
      check("a_busy",      32'(busy_a),      32'(ma.mode != 0));
      check("a_out_acc",   32'(out_acc_a),   32'(ma.exp_acc));
      check("a_out_ovf",   32'(out_ovf_a),   32'(ma.exp_ovf));
      check("b_in_ready",  32'(in_ready_b),  32'(mb.mode == 1));
      check("b_out_valid", 32'(out_valid_b), 32'(mb.mode == 2));
      check("b_busy",      32'(busy_b),      32'(mb.mode != 0));
      check("b_out_acc",   32'(out_acc_b),   32'(mb.exp_acc));
      check("b_out_ovf",   32'(out_ovf_b),   32'(mb.exp_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_const(input int v, input int n);
    for (int k = 0; k < n; k++) begin
      in_sum   = 3'(v);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    ma = '{0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0};
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_in_ready",  32'(in_ready_a),  32'd0);
    check("rst_busy",      32'(busy_a),      32'd0);
    check("rst_out_acc",   32'(out_acc_a),   32'd0);

    // Frame 1: all adder sums i+j, in_valid held high
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        in_sum = 3'(i + j); in_valid = 1'b1; tick();
      end
    end
    in_valid = 1'b0;
    check("f1_out_valid", 32'(out_valid_a), 32'd1);
    check("f1_out_acc",   32'(out_acc_a),   32'd48);
    check("f1_out_ovf",   32'(out_ovf_a),   32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("f1_idle", 32'(busy_a), 32'd0);

    // Frame 2: bubbles every other cycle, consumer stalls 5 cycles, start ignored in HOLD
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        in_sum = 3'(i + j); in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
      end
    end
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      tick();
      check("f2_hold_valid", 32'(out_valid_a), 32'd1);
      check("f2_hold_acc",   32'(out_acc_a),   32'd48);
    end
    start = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("f2_idle", 32'(busy_a), 32'd0);

    // Frame 3: 16 x 7 with a stray start mid-frame; overflows the 5-bit instance
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < N; k++) begin
      in_sum = 3'd7; in_valid = 1'b1; start = (k == 5); tick();
    end
    in_valid = 1'b0; start = 1'b0;
    check("f3_a_acc", 32'(out_acc_a), 32'd112);
    check("f3_a_ovf", 32'(out_ovf_a), 32'd0);
`ifdef ACC_SAT_EN
    check("f3_b_acc", 32'(out_acc_b), 32'd31);
`else
    check("f3_b_acc", 32'(out_acc_b), 32'd16);
`endif
    check("f3_b_ovf", 32'(out_ovf_b), 32'd1);

    // Back-to-back: out_ready and start together restart immediately
    out_ready = 1'b1; start = 1'b1; tick(); out_ready = 1'b0; start = 1'b0;
    check("b2b_in_ready",  32'(in_ready_a),  32'd1);
    check("b2b_out_valid", 32'(out_valid_a), 32'd0);
    feed_const(1, N);
    check("b2b_out_acc", 32'(out_acc_a), 32'd16);
    check("b2b_b_ovf",   32'(out_ovf_b), 32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Reset mid-frame discards the partial sum
    start = 1'b1; tick(); start = 1'b0;
    feed_const(3, 5);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mrst_in_ready",  32'(in_ready_a),  32'd0);
    check("mrst_out_valid", 32'(out_valid_a), 32'd0);
    check("mrst_out_acc",   32'(out_acc_a),   32'd0);
    start = 1'b1; tick(); start = 1'b0;
    feed_const(3, N);
    check("mrst_f_acc", 32'(out_acc_a), 32'd48);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream stage of the 2-bit combinational adder (a[1:0] + b[1:0] -> y[2:0]); consumes its 3-bit sums one per accepted handshake.
- Accumulates a frame of N_SAMPLES sums into a wider register, then presents the frame total with an overflow flag until the consumer takes it.
- Sequential wrapper that turns the adder into a usable datapath element; controlled by a start pulse and valid/ready handshakes on both sides.

Parameters:
- IN_W, 3, width of incoming sum (adder y width)
- ACC_W, 8, accumulator/result width; must be >= IN_W
- N_SAMPLES, 16, sums per frame; range 1..255

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a new frame
- in_valid  input  1  in_sum is valid this cycle
- in_ready  output  1  block accepts in_sum this cycle
- in_sum  input  IN_W  sum from adder y
- out_valid  output  1  out_acc/out_ovf hold a completed frame result
- out_ready  input  1  consumer accepts the result
- out_acc  output  ACC_W  frame total
- out_ovf  output  1  accumulator exceeded 2^ACC_W-1 during the frame
- busy  output  1  high in ACCUM or HOLD

Behaviour:
- Reset: state IDLE; acc=0, count=0, out_acc=0, out_ovf=0, out_valid=0, in_ready=0, busy=0. Reset in any state discards the partial frame; no result is emitted.
- States: IDLE, ACCUM, HOLD (2-bit encoding).
- IDLE: in_ready=0. start=1 -> ACCUM next cycle; acc, count, ovf cleared on that edge.
- ACCUM: in_ready=1 (decoded from registered state only, no combinational path from in_valid). Transfer when in_valid && in_ready: acc <= acc + zero-extended in_sum; count <= count+1. No transfer -> acc/count hold (bubbles allowed). start ignored.
- Frame end: transfer with count == N_SAMPLES-1 -> HOLD next cycle; out_acc/out_ovf load the final value on the same edge; out_valid=1 on the cycle after the last accepted sample (latency 1).
- HOLD: in_ready=0; out_valid=1; out_acc, out_ovf stable until out_ready=1. out_valid && out_ready -> IDLE, or -> ACCUM directly if start=1 in the same cycle (back-to-back frames, fresh clear). start without out_ready ignored.
- Arithmetic: unsigned, modulo 2^ACC_W (wrap). out_ovf sticky within a frame: set on any carry out of bit ACC_W-1; cleared only at frame start or reset.
- out_acc/out_ovf keep the last frame result after leaving HOLD until the next frame end or reset; out_valid qualifies them.
- N_SAMPLES=1: single transfer goes straight to HOLD.

Optional Feature:
- Macro ACC_SAT_EN.
- Defined: accumulator saturates at 2^ACC_W-1; further adds keep it there; out_ovf set on first saturating add.
- Undefined: wrap-around modulo 2^ACC_W as above; out_ovf still set on carry.

Decomposition:
- Shared package adder_pkg: state typedef (ST_IDLE, ST_ACCUM, ST_HOLD), IN_W default constant, helper function for the sum width of two operand widths.
- One natural sub-module: acc_datapath (adder + acc register + wrap/saturate + ovf logic); FSM and counter stay in sum_accumulator.

Test Plan:
- Defaults; start, then feed all 16 adder sums i+j for i,j in 0..3 with in_valid held high -> out_valid one cycle after 16th transfer, out_acc=48, out_ovf=0.
- Same stimulus with in_valid toggled every other cycle and out_ready low for 5 cycles -> out_acc=48 held stable with out_valid=1 throughout; IDLE after out_ready.
- ACC_W=5, 16 samples of 7 -> wrap build: out_acc=16, out_ovf=1; ACC_ACC_SAT_EN build: out_acc=31, out_ovf=1.
- rst=1 after 5 accepted samples -> next cycle IDLE, in_ready=0, out_valid=0, out_acc=0; new frame of 16x3 -> out_acc=48.
- In HOLD assert out_ready and start together -> next cycle ACCUM, in_ready=1, acc cleared; second frame of 16x1 -> out_acc=16.
- start pulsed during ACCUM and HOLD (out_ready=0) -> ignored; count and out_acc unaffected.
